// File: rtl/surf_link_startup_pkg.sv
// rtl/surf_link_startup_pkg.sv - shared state encoding and idle/request patterns for the startup sequencer
package surf_link_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQIN    = 3'd1,
        TRAINOUT = 3'd2,
        GO       = 3'd3,
        LIVE     = 3'd4
    } link_state_e;

    localparam logic [3:0] COUT_IDLE = 4'hF;
    localparam logic [7:0] DOUT_IDLE = 8'hFF;
    localparam logic [7:0] DOUT_REQ  = 8'h00;

    // States that are only meaningful while the local CIN receiver stays aligned
    function automatic logic needs_cin(input link_state_e s);
        return (s == TRAINOUT) || (s == GO) || (s == LIVE);
    endfunction

endpackage

// File: rtl/surf_link_startup_if.sv
// rtl/surf_link_startup_if.sv - control, user data and status bundle of the startup sequencer
interface surf_link_startup_if;
    logic       enable_i;
    logic       rxclk_ok_i;
    logic       cin_trained_i;
    logic       trainout_done_i;
    logic [3:0] cout_data_i;
    logic [7:0] dout_data_i;
    logic [3:0] cout_o;
    logic [7:0] dout_o;
    logic       live_o;
    logic [2:0] state_o;
    logic [7:0] restart_cnt_o;

    modport slave (
        input  enable_i, rxclk_ok_i, cin_trained_i, trainout_done_i, cout_data_i, dout_data_i,
        output cout_o, dout_o, live_o, state_o, restart_cnt_o
    );

    modport master (
        output enable_i, rxclk_ok_i, cin_trained_i, trainout_done_i, cout_data_i, dout_data_i,
        input  cout_o, dout_o, live_o, state_o, restart_cnt_o
    );
endinterface

// File: rtl/surf_link_startup.sv
// rtl/surf_link_startup.sv - SURF-side COUT/DOUT startup sequencer feeding the TURFIO live detector
module surf_link_startup
    import surf_link_pkg::*;
#(
    parameter logic [7:0] DOUT_TRAIN = 8'h6A,
    parameter logic [3:0] COUT_TRAIN = 4'hA,
    parameter int         BOOT_HOLD  = 32
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    surf_link_startup_if.slave   link
);

    localparam int             CNT_W     = $clog2(BOOT_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(BOOT_HOLD - 1);

    if (DOUT_TRAIN == 8'h00 || COUT_TRAIN == 4'hF || BOOT_HOLD < 17) begin : g_param_check
        $error("surf_link_startup: DOUT_TRAIN must be nonzero, COUT_TRAIN not 4'hF, BOOT_HOLD >= 17");
    end

    link_state_e      state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             ok, teardown;
    logic [3:0]       cout_nxt, cout_q;
    logic [7:0]       dout_nxt, dout_q;
    logic             live_nxt, live_q;
    logic [7:0]       restart_cnt;

    assign ok = link.enable_i && link.rxclk_ok_i;

    // Teardown is evaluated ahead of the forward transitions so it always wins
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = '0;
        teardown     = 1'b0;
        if (state != IDLE && (!ok || (needs_cin(state) && !link.cin_trained_i))) begin
            teardown  = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ok) begin
                        if (hold_cnt == HOLD_LAST) state_nxt = REQIN;
                        else                       hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                REQIN:    if (link.cin_trained_i)   state_nxt = TRAINOUT;
                TRAINOUT: if (link.trainout_done_i) state_nxt = GO;
                GO:       state_nxt = LIVE;
                LIVE:     state_nxt = LIVE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cout_nxt = COUT_IDLE;
        dout_nxt = DOUT_IDLE;
        live_nxt = 1'b0;
        case (state)
            REQIN:    dout_nxt = DOUT_REQ;
            TRAINOUT: begin cout_nxt = COUT_TRAIN; dout_nxt = DOUT_TRAIN; end
            GO:       begin cout_nxt = COUT_TRAIN; dout_nxt = DOUT_REQ;   end
            LIVE: begin
                cout_nxt = link.cout_data_i;
                dout_nxt = link.dout_data_i;
                live_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            cout_q      <= COUT_IDLE;
            dout_q      <= DOUT_IDLE;
            live_q      <= 1'b0;
            restart_cnt <= 8'h00;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            cout_q   <= cout_nxt;
            dout_q   <= dout_nxt;
            live_q   <= live_nxt;
            if (teardown && restart_cnt != 8'hFF) restart_cnt <= restart_cnt + 8'h01;
        end
    end

    assign link.cout_o        = cout_q;
    assign link.dout_o        = dout_q;
    assign link.live_o        = live_q;
    assign link.state_o       = state;
    assign link.restart_cnt_o = restart_cnt;

endmodule

// File: tb/tb_surf_link_startup.sv
// tb/tb_surf_link_startup.sv - bench for surf_link_startup with a cycle scoreboard and far-end live detector
module tb_surf_link_startup;

    localparam logic [2:0] S_IDLE = 3'd0, S_REQIN = 3'd1, S_TRAIN = 3'd2, S_GO = 3'd3, S_LIVE = 3'd4;

    typedef struct packed {
        logic [3:0] cout;
        logic [7:0] dout;
        logic       live;
        logic [2:0] st;
        logic [7:0] rc;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    surf_link_startup_if lif();

    surf_link_startup #(.DOUT_TRAIN(8'h6A), .COUT_TRAIN(4'hA), .BOOT_HOLD(32)) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst),
        .link     (lif)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    exp_t e_now, e_chk;
    logic [2:0] m_st;
    int   m_cnt, m_rc;

    // far-end detector state
    int   fe_frun  = 0;
    bit   fe_live  = 1'b0;
    bit   fe_armed = 1'b0;
    bit   fe_saw   = 1'b0;
    bit   fe_mis   = 1'b0;

    function automatic exp_t predict(input logic [2:0] st, input int cnt, input int rc);
        exp_t r;
        bit   okv, torn;
        okv    = lif.enable_i && lif.rxclk_ok_i;
        r      = '0;
        r.cout = 4'hF; r.dout = 8'hFF; r.live = 1'b0;
        if (st == S_REQIN) r.dout = 8'h00;
        if (st == S_TRAIN) begin r.cout = 4'hA; r.dout = 8'h6A; end
        if (st == S_GO)    begin r.cout = 4'hA; r.dout = 8'h00; end
        if (st == S_LIVE)  begin r.cout = lif.cout_data_i; r.dout = lif.dout_data_i; r.live = 1'b1; end
        torn   = (st != S_IDLE) && (!okv || (st >= S_TRAIN && !lif.cin_trained_i));
        r.rc   = 8'(torn ? ((rc == 255) ? 255 : rc + 1) : rc);
        r.st   = st;
        r.cnt  = 8'd0;
        if (torn)                 r.st = S_IDLE;
        else if (st == S_IDLE) begin
            if (okv && cnt == 31) r.st = S_REQIN;
            else if (okv)         r.cnt = 8'(cnt + 1);
        end
        else if (st == S_REQIN && lif.cin_trained_i)   r.st = S_TRAIN;
        else if (st == S_TRAIN && lif.trainout_done_i) r.st = S_GO;
        else if (st == S_GO)                            r.st = S_LIVE;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= S_IDLE; m_cnt <= 0; m_rc <= 0;
            sb_q.delete();
        end else begin
            e_now = predict(m_st, m_cnt, m_rc);
            sb_q.push_back(e_now);
            m_st  <= e_now.st;
            m_cnt <= int'(e_now.cnt);
            m_rc  <= int'(e_now.rc);
        end
    end

    always @(negedge clk) begin
        if (!rst && sb_q.size() > 0) begin
            e_chk = sb_q.pop_front();
            n_total++;
            if ({lif.cout_o, lif.dout_o, lif.live_o, lif.state_o, lif.restart_cnt_o} !==
                {e_chk.cout, e_chk.dout, e_chk.live, e_chk.st, e_chk.rc})
                $display("FAIL sb_cycle t=%0t: got cout=%h dout=%h live=%b st=%0d rc=%0d, want cout=%h dout=%h live=%b st=%0d rc=%0d",
                         $time, lif.cout_o, lif.dout_o, lif.live_o, lif.state_o, lif.restart_cnt_o,
                         e_chk.cout, e_chk.dout, e_chk.live, e_chk.st, e_chk.rc);
            else n_pass++;
        end
        if (lif.cout_o == 4'hF) fe_frun++; else fe_frun = 0;
        if (fe_frun >= 16) begin
            fe_live = 1'b0; fe_armed = 1'b1; fe_saw = 1'b0;
        end else if (fe_armed && !fe_live) begin
            if (lif.dout_o == 8'h6A) fe_saw = 1'b1;
            else if (fe_saw) begin
                if (lif.dout_o == 8'h00) begin fe_live = 1'b1; fe_armed = 1'b0; end
                else fe_mis = 1'b1;
                fe_saw = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic set_in(input logic en, input logic rxok, input logic cin, input logic done);
        lif.enable_i = en; lif.rxclk_ok_i = rxok; lif.cin_trained_i = cin; lif.trainout_done_i = done;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        lif.cout_data_i = 4'h0; lif.dout_data_i = 8'h00;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (lif.state_o === s) begin hit = 1'b1; break; end
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; set_in(0, 0, 0, 0);
        lif.cout_data_i = 4'h0; lif.dout_data_i = 8'h00;
        tick(2);
        n_total++;
        if ({lif.state_o, lif.cout_o, lif.dout_o, lif.live_o, lif.restart_cnt_o} !== {S_IDLE, 4'hF, 8'hFF, 1'b0, 8'h00})
            $display("FAIL reset_values: got st=%0d cout=%h dout=%h live=%b rc=%0d", lif.state_o, lif.cout_o, lif.dout_o, lif.live_o, lif.restart_cnt_o);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_happy_path();
        reset_dut();
        set_in(1, 1, 0, 0);
        tick(31);
        n_total++;
        if (lif.state_o !== S_IDLE) $display("FAIL hold_31: got st=%0d want %0d", lif.state_o, S_IDLE); else n_pass++;
        tick(1);
        n_total++;
        if (lif.state_o !== S_REQIN) $display("FAIL reqin_at_32: got st=%0d want %0d", lif.state_o, S_REQIN); else n_pass++;
        tick(8);
        lif.cin_trained_i = 1'b1;
        tick(2);
        n_total++;
        if ({lif.state_o, lif.cout_o, lif.dout_o} !== {S_TRAIN, 4'hA, 8'h6A})
            $display("FAIL trainout_pattern: got st=%0d cout=%h dout=%h want st=2 cout=a dout=6a", lif.state_o, lif.cout_o, lif.dout_o);
        else n_pass++;
        tick(3);
        lif.trainout_done_i = 1'b1;
        tick(1);
        n_total++;
        if (lif.state_o !== S_GO) $display("FAIL go_state: got st=%0d want %0d", lif.state_o, S_GO); else n_pass++;
        tick(1);
        n_total++;
        if ({lif.state_o, lif.cout_o, lif.dout_o} !== {S_LIVE, 4'hA, 8'h00})
            $display("FAIL go_pattern: got st=%0d cout=%h dout=%h want st=4 cout=a dout=00", lif.state_o, lif.cout_o, lif.dout_o);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            lif.cout_data_i = 4'($urandom_range(0, 14));
            lif.dout_data_i = 8'($urandom);
            tick(1);
        end
        n_total++;
        if ({fe_live, fe_mis, lif.live_o} !== 3'b101)
            $display("FAIL far_end_live: got fe_live=%b fe_mis=%b live_o=%b want 1 0 1", fe_live, fe_mis, lif.live_o);
        else n_pass++;
    endtask

    task automatic test_idle_hold();
        reset_dut();
        set_in(1, 1, 0, 0);
        tick(20);
        lif.rxclk_ok_i = 1'b0;
        tick(3);
        lif.rxclk_ok_i = 1'b1;
        tick(31);
        n_total++;
        if (lif.state_o !== S_IDLE) $display("FAIL rehold_31: got st=%0d want %0d", lif.state_o, S_IDLE); else n_pass++;
        tick(1);
        n_total++;
        if (lif.state_o !== S_REQIN) $display("FAIL rehold_32: got st=%0d want %0d", lif.state_o, S_REQIN); else n_pass++;
    endtask

    task automatic test_teardown_live();
        bit hit;
        reset_dut();
        set_in(1, 1, 1, 1);
        wait_state(S_LIVE, 100, hit);
        lif.cout_data_i = 4'h3; lif.dout_data_i = 8'h5C;
        tick(4);
        n_total++;
        if (!hit || !fe_live) $display("FAIL reach_live: got hit=%b fe_live=%b want 1 1", hit, fe_live); else n_pass++;
        lif.rxclk_ok_i = 1'b0;
        tick(1);
        n_total++;
        if ({lif.state_o, lif.restart_cnt_o} !== {S_IDLE, 8'd1})
            $display("FAIL teardown_state: got st=%0d rc=%0d want 0 1", lif.state_o, lif.restart_cnt_o);
        else n_pass++;
        tick(1);
        n_total++;
        if ({lif.cout_o, lif.dout_o, lif.live_o} !== {4'hF, 8'hFF, 1'b0})
            $display("FAIL teardown_out: got cout=%h dout=%h live=%b want f ff 0", lif.cout_o, lif.dout_o, lif.live_o);
        else n_pass++;
        tick(14);
        n_total++;
        if (fe_live !== 1'b1) $display("FAIL fe_live_15: got %b want 1", fe_live); else n_pass++;
        tick(1);
        n_total++;
        if (fe_live !== 1'b0) $display("FAIL fe_drop_16: got %b want 0", fe_live); else n_pass++;
    endtask

    task automatic test_simultaneous();
        bit hit;
        reset_dut();
        set_in(1, 1, 1, 0);
        wait_state(S_TRAIN, 60, hit);
        n_total++;
        if (!hit) $display("FAIL sim_reach_train: got st=%0d want %0d", lif.state_o, S_TRAIN); else n_pass++;
        lif.cin_trained_i = 1'b0; lif.trainout_done_i = 1'b1;
        tick(1);
        n_total++;
        if ({lif.state_o, lif.restart_cnt_o} !== {S_IDLE, 8'd1})
            $display("FAIL sim_priority: got st=%0d rc=%0d want 0 1", lif.state_o, lif.restart_cnt_o);
        else n_pass++;
    endtask

    task automatic test_saturation();
        bit hit;
        reset_dut();
        set_in(1, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            wait_state(S_REQIN, 40, hit);
            n_total++;
            if (!hit) begin $display("FAIL sat_reach_reqin: iter=%0d got st=%0d want %0d", i, lif.state_o, S_REQIN); break; end
            n_pass++;
            lif.rxclk_ok_i = 1'b0;
            tick(1);
            lif.rxclk_ok_i = 1'b1;
            if (i == 253) begin
                n_total++;
                if (lif.restart_cnt_o !== 8'hFE) $display("FAIL sat_254: got %h want fe", lif.restart_cnt_o); else n_pass++;
            end
        end
        n_total++;
        if (lif.restart_cnt_o !== 8'hFF) $display("FAIL sat_final: got %h want ff", lif.restart_cnt_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit hit;
        reset_dut();
        set_in(1, 1, 0, 0);
        wait_state(S_REQIN, 40, hit);
        lif.enable_i = 1'b0;
        tick(1);
        lif.enable_i = 1'b1; lif.cin_trained_i = 1'b1;
        wait_state(S_TRAIN, 60, hit);
        tick(2);
        n_total++;
        if (!hit || {lif.cout_o, lif.dout_o, lif.restart_cnt_o} !== {4'hA, 8'h6A, 8'd1})
            $display("FAIL ar_setup: got hit=%b cout=%h dout=%h rc=%0d want 1 a 6a 1", hit, lif.cout_o, lif.dout_o, lif.restart_cnt_o);
        else n_pass++;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({lif.state_o, lif.cout_o, lif.dout_o, lif.live_o, lif.restart_cnt_o} !== {S_IDLE, 4'hF, 8'hFF, 1'b0, 8'h00})
            $display("FAIL async_reset: got st=%0d cout=%h dout=%h live=%b rc=%0d want 0 f ff 0 0",
                     lif.state_o, lif.cout_o, lif.dout_o, lif.live_o, lif.restart_cnt_o);
        else n_pass++;
        tick(1);
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        tick(2);
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_idle_hold();
        test_teardown_live();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
